// File: rtl/hcsr04_pkg.sv
// Shared definitions for the HC-SR04 emulator and the measurement interface:
// state/debug codes, 50 MHz timing defaults and the counter width.
package hcsr04_pkg;

    localparam int CONT_W = 22;

    localparam int unsigned CICLOS_TRIG_MIN_DEF = 500;
    localparam int unsigned CICLOS_RAJADA_DEF   = 10000;
    localparam int unsigned CICLOS_POR_CM_DEF   = 2941;
    localparam int unsigned DIST_MAX_DEF        = 400;
    localparam int unsigned CICLOS_TIMEOUT_DEF  = 1900000;
    localparam int unsigned CICLOS_HOLDOFF_DEF  = 500000;

    // Encodings double as the db_estado codes seen on the debug port.
    typedef enum logic [3:0] {
        REPOUSO      = 4'h0,
        TRIG_ALTO    = 4'h1,
        ESPERA_QUEDA = 4'h2,
        RAJADA       = 4'h3,
        ECO          = 4'h4,
        HOLDOFF      = 4'h5
    } estado_e;

    localparam logic [3:0] DB_ILEGAL = 4'hE;

endpackage

// File: rtl/hcsr04_contador_ciclos.sv
// contador_ciclos: loadable 22-bit up/down cycle counter shared by every
// emulator state; fim flags that the count equals the requested target.
module contador_ciclos
    import hcsr04_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              zera,
    input  logic              carrega,
    input  logic              conta,
    input  logic              desce,
    input  logic [CONT_W-1:0] valor,
    input  logic [CONT_W-1:0] alvo,
    output logic              fim
);

    logic [CONT_W-1:0] cont_q;
    logic [CONT_W-1:0] cont_d;

    // NOTE: cont_d gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        cont_d = cont_q;
        if (carrega) begin
            cont_d = valor;
        end else if (zera) begin
            cont_d = '0;
        end else if (conta) begin
            cont_d = desce ? cont_q - CONT_W'(1) : cont_q + CONT_W'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments only.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cont_q <= '0;
        end else begin
            cont_q <= cont_d;
        end
    end

    assign fim = (cont_q == alvo);

endmodule

// File: rtl/hcsr04_emulador.sv
// HC-SR04 sensor emulator: trigger in, delayed echo pulse out whose width encodes distancia.
// Optional echo-width jitter from an 8-bit LFSR when HCSR04_EMU_RUIDO_EN is defined.
module hcsr04_emulador
    import hcsr04_pkg::*;
#(
    parameter int unsigned CICLOS_TRIG_MIN = CICLOS_TRIG_MIN_DEF,
    parameter int unsigned CICLOS_RAJADA   = CICLOS_RAJADA_DEF,
    parameter int unsigned CICLOS_POR_CM   = CICLOS_POR_CM_DEF,
    parameter int unsigned DIST_MAX        = DIST_MAX_DEF,
    parameter int unsigned CICLOS_TIMEOUT  = CICLOS_TIMEOUT_DEF,
    parameter int unsigned CICLOS_HOLDOFF  = CICLOS_HOLDOFF_DEF
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       trigger,
    input  logic [8:0] distancia,
    input  logic       habilita,
    output logic       echo,
    output logic       ocupado,
    output logic [3:0] db_estado
);

    estado_e           state_q, state_d;
    logic [1:0]        sinc_q, sinc_d;
    logic [8:0]        dist_q, dist_d;
    logic              armado_q, armado_d;
    logic              echo_q, echo_d;
    logic              trig_s;
    logic              aceita;
    logic [CONT_W-1:0] largura;
    logic [CONT_W-1:0] jitter;
    logic [CONT_W-1:0] alvo;
    logic              zera, carrega, conta, desce, fim;

    // NOTE: trigger comes from another clock domain; two flops before any use.
    assign sinc_d = {sinc_q[0], trigger};
    assign trig_s = sinc_q[1];

    always_comb begin
        state_d = state_q;
        case (state_q)
            REPOUSO:      if (habilita && trig_s && armado_q) state_d = TRIG_ALTO;
            TRIG_ALTO:    if (!trig_s) state_d = REPOUSO;
                          else if (fim) state_d = ESPERA_QUEDA;
            ESPERA_QUEDA: if (!trig_s) state_d = RAJADA;
            RAJADA:       if (fim) state_d = ECO;
            ECO:          if (fim) state_d = HOLDOFF;
            HOLDOFF:      if (fim) state_d = REPOUSO;
            default:      state_d = REPOUSO;
        endcase
        if (!habilita) state_d = REPOUSO;
    end

    assign aceita = (state_q == TRIG_ALTO) && (state_d == ESPERA_QUEDA);
    assign dist_d = aceita ? distancia : dist_q;
    assign echo_d = (state_d == ECO);

    // A trigger seen high during HOLDOFF must fall before it can start a new measurement.
    always_comb begin
        armado_d = armado_q;
        if (!trig_s) begin
            armado_d = 1'b1;
        end else if (state_q == HOLDOFF) begin
            armado_d = 1'b0;
        end
    end

    always_comb begin
        if (dist_q != 9'd0 && 32'(dist_q) <= DIST_MAX) begin
            largura = CONT_W'(dist_q) * CONT_W'(CICLOS_POR_CM);
        end else begin
            largura = CONT_W'(CICLOS_TIMEOUT);
        end
        largura = largura + jitter;
    end

`ifdef HCSR04_EMU_RUIDO_EN
    logic [7:0] lfsr_q, lfsr_d;

    assign lfsr_d = aceita ? {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]}
                           : lfsr_q;
    assign jitter = {{(CONT_W-4){1'b0}}, lfsr_q[3:0]};

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            lfsr_q <= 8'hA5;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end
`else
    assign jitter = '0;
`endif

    // Up-counting states stop at N-1 (N cycles); ECO loads largura and counts down to 1.
    always_comb begin
        zera    = (state_d != state_q);
        carrega = (state_d != state_q) && (state_d == ECO);
        conta   = (state_q == TRIG_ALTO) || (state_q == RAJADA) ||
                  (state_q == ECO)       || (state_q == HOLDOFF);
        desce   = (state_q == ECO);
        alvo    = '0;
        case (state_q)
            TRIG_ALTO: alvo = CONT_W'(CICLOS_TRIG_MIN - 1);
            RAJADA:    alvo = CONT_W'(CICLOS_RAJADA - 1);
            ECO:       alvo = CONT_W'(1);
            HOLDOFF:   alvo = CONT_W'(CICLOS_HOLDOFF - 1);
            default:   alvo = '0;
        endcase
    end

    contador_ciclos u_contador (
        .clock   (clock),
        .reset   (reset),
        .zera    (zera),
        .carrega (carrega),
        .conta   (conta),
        .desce   (desce),
        .valor   (largura),
        .alvo    (alvo),
        .fim     (fim)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= REPOUSO;
            sinc_q   <= 2'b00;
            dist_q   <= 9'd0;
            armado_q <= 1'b1;
            echo_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            sinc_q   <= sinc_d;
            dist_q   <= dist_d;
            armado_q <= armado_d;
            echo_q   <= echo_d;
        end
    end

    always_comb begin
        db_estado = DB_ILEGAL;
        case (state_q)
            REPOUSO, TRIG_ALTO, ESPERA_QUEDA, RAJADA, ECO, HOLDOFF: db_estado = state_q;
            default: db_estado = DB_ILEGAL;
        endcase
    end

    assign echo    = echo_q;
    assign ocupado = (state_q != REPOUSO);

endmodule
